fifo_word_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_word_packer_flush_timer.sv | 37 +++
 rtl/fifo_word_packer.sv | 98 +++++++++
 tb/tb_fifo_word_packer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_e;

  // Mask with the lowest n bits set; callers slice it to their lane count (up to 32 lanes).
  function automatic logic [31:0] fill_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_word_packer_flush_timer.sv
// Idle counter that signals when a partial word has waited long enough to be flushed.
module flush_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (inc) begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign expire = inc && !clr && (timer_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains narrow FIFO entries and packs PACK_RATIO of them into one wide valid/ready word,
// flushing a partial word after TIMEOUT idle cycles.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  output logic                             fifo_rd_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep
);

  localparam int CNT_W = $clog2(PACK_RATIO + 1);
  localparam logic [CNT_W-1:0] PR_CNT = CNT_W'(PACK_RATIO);

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             pend_q, pend_d;
  logic [DATA_WIDTH*PACK_RATIO-1:0] data_q, data_d;
  logic [PACK_RATIO-1:0]            keep_q, keep_d;
  logic [CNT_W:0]                   inflight;
  logic [31:0]                      mask_full;
  logic                             tmr_inc;
  logic                             tmr_expire;

  // Entries already captured plus the one still in flight must not overrun the word.
  assign inflight   = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
  assign fifo_rd_en = (state_q == FILL) && !fifo_empty && (inflight < {1'b0, PR_CNT});

  assign tmr_inc = (state_q == FILL) && (count_q != '0) && !pend_q && fifo_empty;

  flush_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_flush_timer (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .inc    (tmr_inc),
    .clr    (!tmr_inc),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    keep_d    = keep_q;
    pend_d    = fifo_rd_en;
    mask_full = '0;
    if (state_q == FILL) begin
      if (pend_q) begin
        for (int i = 0; i < PACK_RATIO; i++) begin
          if (count_q == CNT_W'(i)) data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
        end
        count_d   = count_q + 1'b1;
        mask_full = fill_mask(32'(count_d));
        keep_d    = mask_full[PACK_RATIO-1:0];
      end
      // A capture and a timer expiry never coincide: expiry requires pend_q == 0.
      if (count_d == PR_CNT || tmr_expire) begin
        state_d = OUT;
      end
    end else if (out_ready) begin
      state_d = FILL;
      count_d = '0;
      data_d  = '0;
      keep_d  = '0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= FILL;
      count_q <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = data_q;
  assign out_keep  = keep_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO read port.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 16;

  logic           rd_clk = 1'b0;
  logic           rd_rst;
  logic           fifo_empty;
  logic [DW-1:0]  fifo_rd_data = '0;
  logic           fifo_rd_en;
  logic           out_valid;
  logic           out_ready;
  logic [DW*PR-1:0] out_data;
  logic [PR-1:0]  out_keep;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int rd_cnt  = 0;
  int rd_viol = 0;
  int checks  = 0;
  int failures = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_word_packer #(
    .DATA_WIDTH(DW),
    .PACK_RATIO(PR),
    .TIMEOUT   (TO)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_keep    (out_keep)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge rd_clk);
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 64'(out_valid), 64'(1));
  endtask

  initial begin
    int base;
    int err;
    int n;

    rd_rst    = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge rd_clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_keep",  64'(out_keep),  64'(0));
    rd_rst = 1'b0;

    // Full word, downstream always ready
    out_ready = 1'b1;
    base = rd_cnt;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_valid("full");
    chk("full_data",  64'(out_data), 64'h0000_0000_D4C3_B2A1);
    chk("full_keep",  64'(out_keep), 64'hF);
    chk("full_reads", 64'(rd_cnt - base), 64'(4));
    @(negedge rd_clk);
    chk("full_bubble", 64'(out_valid), 64'(0));

    // Backpressure over two words
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("bp1");
    err = 0;
    repeat (20) begin
      @(negedge rd_clk);
      if (!out_valid || out_data !== 32'h0403_0201 || fifo_rd_en) err++;
    end
    chk("bp_hold", 64'(err), 64'(0));
    chk("bp_data1", 64'(out_data), 64'h0403_0201);
    out_ready = 1'b1;
    @(negedge rd_clk);
    chk("bp_bubble", 64'(out_valid), 64'(0));
    wait_valid("bp2");
    chk("bp_data2", 64'(out_data), 64'h0807_0605);
    chk("bp_keep2", 64'(out_keep), 64'hF);
    @(negedge rd_clk);
    out_ready = 1'b0;

    // Partial flush: latency counted from the edge that captures the last byte
    push(8'hA1); push(8'hB2);
    repeat (3) @(negedge rd_clk);
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!out_valid && n < 40);
    chk("flush_latency", 64'(n), 64'(TO));
    chk("flush_data", 64'(out_data), 64'h0000_B2A1);
    chk("flush_keep", 64'(out_keep), 64'h3);
    out_ready = 1'b1;
    @(negedge rd_clk);
    chk("flush_bubble", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Timer race: a byte turns up while the timer sits at TIMEOUT-1
    push(8'hA1); push(8'hB2);
    repeat (3) @(negedge rd_clk);
    repeat (TO - 1) @(negedge rd_clk);
    chk("race_pre", 64'(out_valid), 64'(0));
    push(8'hC3);
    @(negedge rd_clk);
    chk("race_no_flush", 64'(out_valid), 64'(0));
    @(negedge rd_clk);
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!out_valid && n < 40);
    chk("race_restart", 64'(n), 64'(TO));
    chk("race_data", 64'(out_data), 64'h00C3_B2A1);
    chk("race_keep", 64'(out_keep), 64'h7);
    out_ready = 1'b1;
    @(negedge rd_clk);
    out_ready = 1'b0;

    // Empty FIFO: nothing should move
    err = 0;
    repeat (100) begin
      @(negedge rd_clk);
      if (out_valid || fifo_rd_en) err++;
    end
    chk("idle_quiet", 64'(err), 64'(0));

    // Reset while a word is presented
    push(8'h55); push(8'h66);
    wait_valid("rstv");
    chk("rstv_pre", 64'(out_valid), 64'(1));
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("rstv_valid", 64'(out_valid), 64'(0));
    chk("rstv_data",  64'(out_data),  64'(0));
    chk("rstv_keep",  64'(out_keep),  64'(0));
    rd_rst = 1'b0;

    // Reset after two captures, then a clean word
    push(8'h77); push(8'h88);
    repeat (3) @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("rstm_valid", 64'(out_valid), 64'(0));
    chk("rstm_rd_en", 64'(fifo_rd_en), 64'(0));
    rd_rst = 1'b0;
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid("rstm");
    chk("rstm_data", 64'(out_data), 64'h4433_2211);
    chk("rstm_keep", 64'(out_keep), 64'hF);
    @(negedge rd_clk);
    chk("no_empty_reads", 64'(rd_viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
